// File: rtl/subtractor_pipe.sv
// Pipelined N-bit subtractor d = a - b - bi, resolving one W-bit slice per stage (S = N/W stages).
// Latency: S cycles from accept to o_valid; throughput one beat per cycle with o_ready held high.
// Backpressure: per-stage valid/ready; empty stages keep accepting, a full stalled pipe drops i_ready.
//
// Ports: clk/rst (sync, active-high); i_valid/i_ready + a, b, bi operand beat;
//        o_valid/o_ready + d, bo (unsigned borrow-out), ov (signed overflow).
// Optional feature macro: SUBTRACTOR_PIPE_OVF_EN enables ov; when undefined ov is tied to 0.
module subtractor_pipe #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] d,
  output logic         bo,
  output logic         ov
);

  localparam int S = N / W;

  // One W-bit slice with borrow-lookahead: propagate when bits are equal,
  // generate when minuend bit is 0 and subtrahend bit is 1.
  // Returns {borrow_out, difference}.
  function automatic logic [W:0] sub_slice(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         bin);
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;
    p    = ~(x ^ y);
    g    = ~x & y;
    c    = '0;
    c[0] = bin;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[W], (~p) ^ c[W-1:0]};
  endfunction

  logic [S-1:0] vld;
  logic [S-1:0] ready;

  for (genvar k = 0; k < S; k++) begin : gen_stage
    logic                 valid_q;
    logic                 borrow_q;
    logic [(k+1)*W-1:0]   d_q;

    // Operand slices k..S-1 still to be consumed, as seen on this stage's input.
    logic [N-k*W-1:0]     op_a;
    logic [N-k*W-1:0]     op_b;
    logic                 brw_in;
    logic                 vld_in;
    logic [W-1:0]         a_s;
    logic [W-1:0]         b_s;
    logic [W:0]           sub;
    logic [(k+1)*W-1:0]   d_nxt;

    // Stage k can load if any stage from k to the end is empty, or the
    // consumer is taking the last beat: bubbles collapse without a ripple chain.
    assign ready[k] = o_ready | ~(&vld[S-1:k]);
    assign vld[k]   = valid_q;

    if (k == 0) begin : g_in
      assign op_a   = a;
      assign op_b   = b;
      assign brw_in = bi;
      assign vld_in = i_valid;
    end else begin : g_in
      assign op_a   = gen_stage[k-1].g_op.a_q;
      assign op_b   = gen_stage[k-1].g_op.b_q;
      assign brw_in = gen_stage[k-1].borrow_q;
      assign vld_in = gen_stage[k-1].valid_q;
    end

    assign a_s = op_a[W-1:0];
    assign b_s = op_b[W-1:0];
    assign sub = sub_slice(a_s, b_s, brw_in);

    if (k == 0) begin : g_d
      assign d_nxt = sub[W-1:0];
    end else begin : g_d
      assign d_nxt = {sub[W-1:0], gen_stage[k-1].d_q};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q  <= 1'b0;
        borrow_q <= 1'b0;
        d_q      <= '0;
      end else if (ready[k]) begin
        valid_q  <= vld_in;
        borrow_q <= sub[W];
        d_q      <= d_nxt;
      end
    end

    // Unconsumed upper operand slices skew forward; the last stage needs none.
    if (k < S-1) begin : g_op
      logic [N-(k+1)*W-1:0] a_q;
      logic [N-(k+1)*W-1:0] b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ready[k]) begin
          a_q <= op_a[N-k*W-1:W];
          b_q <= op_b[N-k*W-1:W];
        end
      end
    end
  end

  assign i_ready = ready[0] & ~rst;
  assign o_valid = gen_stage[S-1].valid_q;
  assign d       = gen_stage[S-1].d_q;
  assign bo      = gen_stage[S-1].borrow_q;

`ifdef SUBTRACTOR_PIPE_OVF_EN
  // The operand MSBs arrive at the last stage inside the skewed top slice,
  // so overflow is resolved there and registered alongside d.
  logic ov_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
    end else if (ready[S-1]) begin
      ov_q <= (gen_stage[S-1].a_s[W-1] != gen_stage[S-1].b_s[W-1]) &
              (gen_stage[S-1].sub[W-1] != gen_stage[S-1].a_s[W-1]);
    end
  end
  assign ov = ov_q;
`else
  assign ov = 1'b0;
`endif

endmodule

// File: tb/tb_subtractor_pipe.sv
module tb_subtractor_pipe;

  localparam int N = 16;
  localparam int W = 4;
  localparam int S = N / W;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bi;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] d;
  logic         bo;
  logic         ov;

  int checks = 0;
  int errors = 0;

  subtractor_pipe #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .a(a), .b(b), .bi(bi),
    .o_valid(o_valid), .o_ready(o_ready), .d(d), .bo(bo), .ov(ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Reference: {ov, bo, d} from plain integer arithmetic.
  function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N:0] u;
    int         sd;
    logic       o;
    u  = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, c};
    sd = int'($signed(x)) - int'($signed(y)) - int'(c);
    o  = (sd > 32767) || (sd < -32768);
`ifndef SUBTRACTOR_PIPE_OVF_EN
    o  = 1'b0;
`endif
    return {o, u};
  endfunction

  function automatic logic [N-1:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    return r[N-1:0];
  endfunction

  // Single beat through an empty pipe with o_ready=1; reports result and latency.
  task automatic run_beat(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic xbi,
                          output logic [N-1:0] rd, output logic rbo, output logic rov,
                          output int lat);
    int n;
    @(posedge clk); #1;
    i_valid = 1'b1; a = xa; b = xb; bi = xbi; o_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!i_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_valid && lat < 20);
    rd = d; rbo = bo; rov = ov;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; i_valid = 1'b1; a = 16'hABCD; b = 16'h1234; bi = 1'b1; o_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_d: got %h want 0000", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL reset_bo: got %b want 0", bo); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b want 0", ov); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: got %b want 0", i_ready); end
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL release_i_ready: got %b want 1", i_ready); end
  endtask

  task automatic test_basic();
    logic [N-1:0] rd; logic rbo, rov; int lat;
    run_beat(16'h1234, 16'h0234, 1'b0, rd, rbo, rov, lat);
    checks++; if (rd !== 16'h1000) begin errors++; $display("FAIL basic_d: got %h want 1000", rd); end
    checks++; if (rbo !== 1'b0) begin errors++; $display("FAIL basic_bo: got %b want 0", rbo); end
    checks++; if (lat !== S) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, S); end
  endtask

  task automatic test_wrap();
    logic [N-1:0] rd; logic rbo, rov; int lat;
    run_beat(16'h0000, 16'h0001, 1'b0, rd, rbo, rov, lat);
    checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL wrap_b_d: got %h want ffff", rd); end
    checks++; if (rbo !== 1'b1) begin errors++; $display("FAIL wrap_b_bo: got %b want 1", rbo); end
    run_beat(16'h0000, 16'h0000, 1'b1, rd, rbo, rov, lat);
    checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL wrap_bi_d: got %h want ffff", rd); end
    checks++; if (rbo !== 1'b1) begin errors++; $display("FAIL wrap_bi_bo: got %b want 1", rbo); end
  endtask

  task automatic test_overflow();
    logic [N-1:0] rd; logic rbo, rov; int lat;
    logic exp_ov;
`ifdef SUBTRACTOR_PIPE_OVF_EN
    exp_ov = 1'b1;
`else
    exp_ov = 1'b0;
`endif
    run_beat(16'h8000, 16'h0001, 1'b0, rd, rbo, rov, lat);
    checks++; if (rd !== 16'h7FFF) begin errors++; $display("FAIL ovf1_d: got %h want 7fff", rd); end
    checks++; if (rbo !== 1'b0) begin errors++; $display("FAIL ovf1_bo: got %b want 0", rbo); end
    checks++; if (rov !== exp_ov) begin errors++; $display("FAIL ovf1_ov: got %b want %b", rov, exp_ov); end
    run_beat(16'h7FFF, 16'hFFFF, 1'b0, rd, rbo, rov, lat);
    checks++; if (rd !== 16'h8000) begin errors++; $display("FAIL ovf2_d: got %h want 8000", rd); end
    checks++; if (rbo !== 1'b1) begin errors++; $display("FAIL ovf2_bo: got %b want 1", rbo); end
    checks++; if (rov !== exp_ov) begin errors++; $display("FAIL ovf2_ov: got %b want %b", rov, exp_ov); end
  endtask

  task automatic test_back_to_back();
    logic [N+1:0] expq[$];
    logic [N+1:0] exp_v;
    logic [N+1:0] got;
    logic [N+1:0] held_v;
    logic         held;
    logic         acc;
    int           sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; held = 1'b0; acc = 1'b1;
    held_v = '0;
    while (recv < 100 && cyc < 3000) begin
      @(posedge clk); #1;
      if (acc) begin
        if (sent < 100) begin
          i_valid = 1'b1; a = rnd16(); b = rnd16(); bi = $urandom_range(0, 1) == 1;
        end else begin
          i_valid = 1'b0;
        end
      end
      o_ready = $urandom_range(0, 1) == 1;
      @(negedge clk);
      acc = 1'b0;
      if (i_valid && i_ready) begin
        expq.push_back(model(a, b, bi));
        sent++;
        acc = 1'b1;
      end
      got = {ov, bo, d};
      if (held) begin
        checks++;
        if (o_valid !== 1'b1 || got !== held_v) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h want v=1 %h", o_valid, got, held_v);
        end
      end
      held = 1'b0;
      if (o_valid === 1'b1) begin
        if (o_ready) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL stream_extra: unexpected result %h", got);
          end else begin
            exp_v = expq.pop_front();
            if (got !== exp_v) begin
              errors++;
              $display("FAIL stream_data[%0d]: got %h want %h", recv, got, exp_v);
            end
          end
          recv++;
        end else begin
          held = 1'b1;
          held_v = got;
        end
      end
      cyc++;
    end
    i_valid = 1'b0;
    checks++; if (recv !== 100) begin errors++; $display("FAIL stream_count: got %0d want 100", recv); end
  endtask

  task automatic test_reset_flush();
    logic [N-1:0] rd; logic rbo, rov; int lat;
    int cnt, cyc, stale;
    logic [N+1:0] e;
    cnt = 0; cyc = 0;
    @(posedge clk); #1;
    o_ready = 1'b0; i_valid = 1'b1; a = rnd16(); b = rnd16(); bi = 1'b0;
    while (cnt < S && cyc < 50) begin
      @(negedge clk);
      if (i_valid && i_ready) cnt++;
      @(posedge clk); #1;
      if (cnt == S) i_valid = 1'b0;
      else begin a = rnd16(); b = rnd16(); end
      cyc++;
    end
    i_valid = 1'b1;
    @(negedge clk);
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL full_i_ready: got %b want 0", i_ready); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL full_o_valid: got %b want 1", o_valid); end
    @(posedge clk); #1;
    i_valid = 1'b0; o_ready = 1'b1;
    @(negedge clk);
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL unstall_i_ready: got %b want 1", i_ready); end
    @(posedge clk); #1;
    o_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; o_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_valid !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL flush_stale: got %0d stale cycles want 0", stale); end
    e = model(16'h5A5A, 16'h1234, 1'b1);
    run_beat(16'h5A5A, 16'h1234, 1'b1, rd, rbo, rov, lat);
    checks++; if ({rov, rbo, rd} !== e) begin errors++; $display("FAIL post_reset_beat: got %h want %h", {rov, rbo, rd}, e); end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; a = '0; b = '0; bi = 1'b0; o_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_back_to_back();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
